// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: owns L/R and C/D state and steps one Feistel round
// per clock through an external f-function (PC-2, E, S-boxes, P).
module des_round_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        decrypt,
   input  logic [63:0] blk_in,
   input  logic [55:0] key_in,
   output logic [31:0] f_r_o,
   output logic [55:0] f_cd_o,
   input  logic [31:0] f_res_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] blk_out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   // Bit (i-1) set where the DES shift table entry S[i] is 1 (rounds 1, 2, 9, 16).
   localparam logic [15:0] SHIFT_ONE = 16'h8103;

   state_t      state, state_nxt;
   logic [31:0] l_q, r_q, l_nxt, r_nxt;
   logic [27:0] c_q, d_q, c_nxt, d_nxt;
   logic        mode_q, mode_nxt;
   logic [3:0]  cnt_q, cnt_nxt;
   logic [3:0]  enc_idx, dec_idx;
   logic        enc_two, dec_two;

   function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   // Encrypt after round i rotates by S[i+1]; decrypt by S[17-i]. With i = cnt+1
   // those are table positions cnt+1 and 15-cnt (zero-based).
   assign enc_idx = cnt_q + 4'd1;
   assign dec_idx = 4'd15 - cnt_q;
   assign enc_two = ~SHIFT_ONE[enc_idx];
   assign dec_two = ~SHIFT_ONE[dec_idx];

   always_comb begin
      state_nxt = state;
      l_nxt     = l_q;
      r_nxt     = r_q;
      c_nxt     = c_q;
      d_nxt     = d_q;
      mode_nxt  = mode_q;
      cnt_nxt   = cnt_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = ROUND;
               l_nxt     = blk_in[63:32];
               r_nxt     = blk_in[31:0];
               mode_nxt  = decrypt;
               cnt_nxt   = 4'd0;
               if (decrypt) begin
                  c_nxt = key_in[55:28];
                  d_nxt = key_in[27:0];
               end else begin
                  c_nxt = rot_l(key_in[55:28], 1'b0);
                  d_nxt = rot_l(key_in[27:0], 1'b0);
               end
            end
         end
         ROUND: begin
            l_nxt = r_q;
            r_nxt = l_q ^ f_res_i;
            if (cnt_q == 4'd15) begin
               // C/D already sit at C0/D0 after the last round in both modes; hold them.
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt_q + 4'd1;
               if (mode_q) begin
                  c_nxt = rot_r(c_q, dec_two);
                  d_nxt = rot_r(d_q, dec_two);
               end else begin
                  c_nxt = rot_l(c_q, enc_two);
                  d_nxt = rot_l(d_q, enc_two);
               end
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         l_q    <= '0;
         r_q    <= '0;
         c_q    <= '0;
         d_q    <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         l_q    <= l_nxt;
         r_q    <= r_nxt;
         c_q    <= c_nxt;
         d_q    <= d_nxt;
         mode_q <= mode_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == ROUND);
   assign f_r_o     = r_q;
   assign f_cd_o    = {c_q, d_q};
   // L/R are frozen outside ROUND, so the swapped block is stable throughout DONE.
   assign blk_out   = {r_q, l_q};

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: external DES f-function, scoreboard fed by a full DES
// reference model, directed vectors plus randomized traffic with random backpressure.
module tb_des_round_ctrl;

   localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int SBOX [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   localparam logic [55:0] VKEY = 56'hF0CCAAF556678F;
   localparam logic [63:0] VBLK = 64'hCC00CCFFF0AAF0AA;
   localparam logic [63:0] VRES = 64'h0A4CD99543423234;
   localparam logic [63:0] VCT  = 64'h85E813540F0AB405;
   localparam logic [63:0] VPT  = 64'h0123456789ABCDEF;

   logic        clk, rst_n, in_valid, in_ready, decrypt, out_valid, out_ready, busy;
   logic [63:0] blk_in, blk_out;
   logic [55:0] key_in, f_cd_o;
   logic [31:0] f_r_o, f_res_i;

   int          checks, errors, cyc;
   bit          rnd_rdy, force_rdy;
   logic [63:0] exp_q[$];
   int          acc_cyc[$];

   des_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .decrypt(decrypt), .blk_in(blk_in), .key_in(key_in), .f_r_o(f_r_o),
      .f_cd_o(f_cd_o), .f_res_i(f_res_i), .out_valid(out_valid), .out_ready(out_ready),
      .blk_out(blk_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] k;
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      return k;
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s, f;
      logic [5:0]  b;
      int          sidx;
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ k;
      for (int j = 0; j < 8; j++) begin
         b = e[47-6*j -: 6];
         sidx = 32*int'(b[5]) + 16*int'(b[0]) + int'(b[4:1]);
         s[31-4*j -: 4] = 4'(SBOX[j][sidx]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
      return f;
   endfunction

   function automatic logic [63:0] ip64(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
      return o;
   endfunction

   function automatic logic [63:0] fp64(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
      return o;
   endfunction

   // Textbook DES on the post-IP block and post-PC-1 key; returns pre-FP {R16, L16}.
   function automatic logic [63:0] des_model(input logic [63:0] b, input logic [55:0] k, input logic dec);
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [31:0] l, r, t;
      c = k[55:28];
      d = k[27:0];
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < SH_T[i]; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[i] = pc2({c, d});
      end
      l = b[63:32];
      r = b[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ f_func(r, dec ? ks[15-i] : ks[i]);
         l = t;
      end
      return {r, l};
   endfunction

   always_comb f_res_i = f_func(f_r_o, pc2(f_cd_o));

   always @(posedge clk) begin
      #2;
      out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard producer: expected result computed at the accepting edge.
   always @(negedge clk)
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(des_model(blk_in, key_in, decrypt));
         acc_cyc.push_back(cyc);
      end

   // Scoreboard consumer.
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_out", blk_out, 64'hx);
         else chk("blk_out", blk_out, exp_q.pop_front());
      end

   task automatic issue(input logic [63:0] b, input logic [55:0] k, input logic d, input bit hold);
      logic [63:0] t;
      bit ok;
      @(posedge clk); #1;
      blk_in = b; key_in = k; decrypt = d; in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      if (!hold) begin
         t = {$urandom(), $urandom()};
         in_valid = 1'b0;
         decrypt  = ~d;
         blk_in   = t;
         key_in   = ~k;
      end
   endtask

   task automatic run_vec(input logic [63:0] b, input logic [55:0] k, input logic d,
                          output logic [63:0] res, output int lat,
                          output logic [55:0] cd1, output logic [55:0] cd16, output logic bz);
      res = '0; lat = -1; cd1 = '0; cd16 = '0; bz = 1'b0;
      issue(b, k, d, 0);
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         if (i == 1) begin cd1 = f_cd_o; bz = busy; end
         if (i == 16) cd16 = f_cd_o;
         if (out_valid) begin res = blk_out; lat = i - 1; break; end
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && in_ready) break;
      end
      chk("drain_queue", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [63:0] res, t, u;
      logic [55:0] cd1, cd16;
      logic        bz;
      int          lat, n0;
      bit          ok;
      checks = 0; errors = 0; cyc = 0;
      rnd_rdy = 0; force_rdy = 1;
      rst_n = 0; in_valid = 0; decrypt = 0; blk_in = '0; key_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_blk_out", blk_out, 64'd0);
      chk("rst_f_r", {32'd0, f_r_o}, 64'd0);
      chk("rst_f_cd", {8'd0, f_cd_o}, 64'd0);
      rst_n = 1;

      // Encrypt vector and key schedule trace
      run_vec(VBLK, VKEY, 1'b0, res, lat, cd1, cd16, bz);
      chk("enc_result", res, VRES);
      chk("enc_latency", 64'(lat), 64'd16);
      chk("enc_cd_r1", {8'd0, cd1}, {8'd0, 56'hE19955FAACCF1E});
      chk("enc_cd_r16", {8'd0, cd16}, {8'd0, VKEY});
      chk("busy_in_round", {63'd0, bz}, 64'd1);
      wait_drain();

      // Decrypt vector
      run_vec(ip64(VCT), VKEY, 1'b1, res, lat, cd1, cd16, bz);
      chk("dec_plaintext", fp64(res), VPT);
      chk("dec_latency", 64'(lat), 64'd16);
      chk("dec_cd_r1", {8'd0, cd1}, {8'd0, VKEY});
      wait_drain();

      // Output backpressure, with the next request already waiting
      force_rdy = 0;
      issue(VBLK, VKEY, 1'b0, 1);
      blk_in = ip64(VCT); decrypt = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      chk("bp_reach_done", {63'd0, ok}, 64'd1);
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_blk_out", blk_out, VRES);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      force_rdy = 1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_after", {63'd0, in_ready}, 64'd1);
      chk("bp_valid_drop", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      in_valid = 0;
      wait_drain();

      // Reset in round 7
      issue(VBLK, VKEY, 1'b0, 0);
      repeat (7) @(negedge clk);
      rst_n = 0;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_f_r", {32'd0, f_r_o}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1;
      run_vec(VBLK, VKEY, 1'b0, res, lat, cd1, cd16, bz);
      chk("post_rst_result", res, VRES);
      chk("post_rst_latency", 64'(lat), 64'd16);
      wait_drain();

      // Back-to-back: encrypt then decrypt with a different key, in_valid held
      n0 = acc_cyc.size();
      t = {$urandom(), $urandom()};
      u = {$urandom(), $urandom()};
      issue(t, u[55:0], 1'b0, 1);
      blk_in = ip64(VCT); key_in = VKEY; decrypt = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (acc_cyc.size() >= n0 + 2) break;
      end
      @(posedge clk); #1;
      in_valid = 0;
      chk("b2b_accepts", 64'(acc_cyc.size()), 64'(n0 + 2));
      if (acc_cyc.size() >= n0 + 2)
         chk("b2b_spacing", 64'(acc_cyc[n0+1] - acc_cyc[n0]), 64'd18);
      wait_drain();

      // Randomized traffic under random output backpressure
      rnd_rdy = 1;
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         t = {$urandom(), $urandom()};
         u = {$urandom(), $urandom()};
         issue(t, u[55:0], 1'($urandom_range(0, 1)), 0);
      end
      wait_drain();
      rnd_rdy = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
